// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types for the I2C/host register memory arbiter
package i2c_arb_pkg;

  // Sequencer states: pick a requester, strobe memory, wait for read data, report completion
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // Which requester owns the access currently in flight
  typedef enum logic {
    OWN_I2C  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  // Counter width able to hold 0..max_val inclusive
  function automatic int unsigned count_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/i2c_toggle_sync.sv
// rtl/i2c_toggle_sync.sv - multi-flop synchroniser for the SCL-domain request toggle
module i2c_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl_in,
  output logic tgl_sync
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous toggle through the flop chain; the last flop is safe to use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], tgl_in};
    end
  end

  assign tgl_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_mem_arbiter.sv
// rtl/i2c_mem_arbiter.sv - arbitrates one register memory between I2C and host; optional I2C_ARB_WP_EN write protect
module i2c_mem_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int AW              = 8,
  parameter int DW              = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int HOST_STARVE_MAX = 4,
  parameter int WP_BOUNDARY     = 'hF0
) (
  input  logic          clk,
  input  logic          rst_n,
  // I2C subordinate side (SCL domain, toggle handshake)
  input  logic          i2c_req_tgl,
  input  logic          i2c_we,
  input  logic [AW-1:0] i2c_addr,
  input  logic [DW-1:0] i2c_wdata,
  output logic          i2c_ack_tgl,
  output logic [DW-1:0] i2c_rdata,
  output logic          hold_clock_low,
  // Local host side
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_done,
  output logic [DW-1:0] host_rdata,
`ifdef I2C_ARB_WP_EN
  output logic          wp_violation,
`endif
  // Single-port memory
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = count_width(HOST_STARVE_MAX);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(HOST_STARVE_MAX);
  localparam logic [AW-1:0] WP_ADDR = AW'(WP_BOUNDARY);

`ifdef I2C_ARB_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  arb_state_t     state, state_nxt;
  owner_t         owner, load_owner;
  logic           load;
  logic           ack_fire;
  logic           tgl_synced;
  logic           ack_q;
  logic           hcl_q;
  logic           i2c_pend;
  logic           host_starved;
  logic           pick_i2c;
  logic           pick_host;
  logic           wp_hit;
  logic [CW-1:0]  starve_cnt;
  logic           lat_we;
  logic [AW-1:0]  lat_addr;
  logic [DW-1:0]  lat_wdata;
  logic [DW-1:0]  i2c_rdata_q;
  logic [DW-1:0]  host_rdata_q;

  i2c_toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .tgl_in  (i2c_req_tgl),
    .tgl_sync(tgl_synced)
  );

  // Only the parity difference between request and ack toggles matters
  assign i2c_pend     = tgl_synced ^ ack_q;
  assign host_starved = host_req && (starve_cnt == STARVE_LIMIT);
  assign pick_i2c     = i2c_pend && !host_starved;
  assign pick_host    = !pick_i2c && host_req;
  assign wp_hit       = WP_ON && i2c_we && (i2c_addr >= WP_ADDR);

  // State register; an async reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode; completion flags become visible in DONE
  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    host_done  = 1'b0;
    load       = 1'b0;
    load_owner = OWN_I2C;
    ack_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_i2c) begin
          load       = 1'b1;
          load_owner = OWN_I2C;
          if (wp_hit) begin
            state_nxt = DONE;
            ack_fire  = 1'b1;
          end else begin
            state_nxt = ACCESS;
          end
        end else if (pick_host) begin
          load       = 1'b1;
          load_owner = OWN_HOST;
          state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        mem_en = 1'b1;
        if (lat_we) begin
          state_nxt = DONE;
          ack_fire  = (owner == OWN_I2C);
        end else begin
          state_nxt = RDWAIT;
        end
      end
      RDWAIT: begin
        state_nxt = DONE;
        ack_fire  = (owner == OWN_I2C);
      end
      DONE: begin
        host_done = (owner == OWN_HOST);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winning request so the requester may move on once it is complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_I2C;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (load) begin
      owner     <= load_owner;
      lat_we    <= (load_owner == OWN_I2C) ? i2c_we    : host_we;
      lat_addr  <= (load_owner == OWN_I2C) ? i2c_addr  : host_addr;
      lat_wdata <= (load_owner == OWN_I2C) ? i2c_wdata : host_wdata;
    end
  end

  // Ack toggles on the edge entering DONE so it lands together with the read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
    end else if (ack_fire) begin
      ack_q <= ~ack_q;
    end
  end

  // SCL is stretched while an I2C request is outstanding (one clk of lag is tolerated)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcl_q <= 1'b0;
    end else begin
      hcl_q <= i2c_pend;
    end
  end

  // Memory returns data one cycle after the strobe; route it to the owner's holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2c_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else if (state == RDWAIT) begin
      if (owner == OWN_I2C) begin
        i2c_rdata_q <= mem_rdata;
      end else begin
        host_rdata_q <= mem_rdata;
      end
    end
  end

  // Count I2C grants taken while the host waits; forces one host grant at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!host_req) begin
      starve_cnt <= '0;
    end else if ((state == IDLE) && pick_host) begin
      starve_cnt <= '0;
    end else if ((state == IDLE) && pick_i2c && (starve_cnt != STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

`ifdef I2C_ARB_WP_EN
  logic lat_wp;

  // Remember that the I2C request was refused so DONE can flag it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_wp <= 1'b0;
    end else if (load) begin
      lat_wp <= pick_i2c && wp_hit;
    end
  end

  assign wp_violation = (state == DONE) && lat_wp;
`endif

  assign i2c_ack_tgl    = ack_q;
  assign i2c_rdata      = i2c_rdata_q;
  assign hold_clock_low = hcl_q;
  assign host_rdata     = host_rdata_q;
  assign mem_we         = mem_en && lat_we;
  assign mem_addr       = lat_addr;
  assign mem_wdata      = lat_wdata;

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// tb/tb_i2c_mem_arbiter.sv - directed self-checking bench for i2c_mem_arbiter
module tb_i2c_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       i2c_req_tgl;
  logic       i2c_we;
  logic [7:0] i2c_addr;
  logic [7:0] i2c_wdata;
  logic       i2c_ack_tgl;
  logic [7:0] i2c_rdata;
  logic       hold_clock_low;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_done;
  logic [7:0] host_rdata;
`ifdef I2C_ARB_WP_EN
  logic       wp_violation;
`endif
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int         n_checks = 0;
  int         n_errors = 0;
  logic       tgl;
  bit         ok;
  int         wp_cnt;
  logic [7:0] tb_mem [256];
  logic [7:0] strobe_log [$];
  logic [7:0] exp_order [7] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h80, 8'h35};

  i2c_mem_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i2c_req_tgl   (i2c_req_tgl),
    .i2c_we        (i2c_we),
    .i2c_addr      (i2c_addr),
    .i2c_wdata     (i2c_wdata),
    .i2c_ack_tgl   (i2c_ack_tgl),
    .i2c_rdata     (i2c_rdata),
    .hold_clock_low(hold_clock_low),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_done     (host_done),
    .host_rdata    (host_rdata),
`ifdef I2C_ARB_WP_EN
    .wp_violation  (wp_violation),
`endif
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with one cycle of read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  // Record every memory strobe address in grant order
  always @(negedge clk) begin
    if (mem_en) strobe_log.push_back(mem_addr);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_issue(input logic we, input logic [7:0] a, input logic [7:0] d);
    i2c_we      = we;
    i2c_addr    = a;
    i2c_wdata   = d;
    tgl         = ~tgl;
    i2c_req_tgl = tgl;
  endtask

  task automatic wait_strobe(input logic [7:0] a, output bit found);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (host_done) host_req = 1'b0;
      if (mem_en && (mem_addr == a)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(output bit quiet);
    quiet = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (host_done) host_req = 1'b0;
      if (!host_req && (i2c_ack_tgl == tgl)) begin
        quiet = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; tgl = 1'b0; i2c_req_tgl = 1'b0; i2c_we = 1'b0; i2c_addr = '0; i2c_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) step();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_ack", i2c_ack_tgl, 0);
    check("rst_hold", hold_clock_low, 0);
    check("rst_host_done", host_done, 0);
    check("rst_i2c_rdata", i2c_rdata, 0);
    check("rst_host_rdata", host_rdata, 0);
    rst_n = 1'b1;
    step();

    // I2C write 0x10 <= 0xA5: strobe, then ack in the following cycle
    strobe_log.delete();
    i2c_issue(1'b1, 8'h10, 8'hA5);
    wait_strobe(8'h10, ok);
    check("wr_strobe_seen", ok, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_wdata", mem_wdata, 8'hA5);
    check("wr_hold_in_access", hold_clock_low, 1);
    check("wr_ack_not_yet", i2c_ack_tgl, 0);
    step();
    check("wr_ack_toggled", i2c_ack_tgl, 1);
    check("wr_hold_in_done", hold_clock_low, 1);
    step();
    check("wr_hold_released", hold_clock_low, 0);
    check("wr_single_strobe", strobe_log.size(), 1);

    // I2C read 0x10: ack two cycles after the strobe carrying 0xA5
    i2c_issue(1'b0, 8'h10, 8'h00);
    wait_strobe(8'h10, ok);
    check("rd_strobe_seen", ok, 1);
    check("rd_mem_we", mem_we, 0);
    step();
    check("rd_ack_not_yet", i2c_ack_tgl, 1);
    step();
    check("rd_ack_toggled", i2c_ack_tgl, 0);
    check("rd_i2c_rdata", i2c_rdata, 8'hA5);
    check("rd_hold_in_done", hold_clock_low, 1);
    step();
    check("rd_hold_released", hold_clock_low, 0);

    // Async reset during an I2C access aborts it with no ack
    i2c_issue(1'b0, 8'h10, 8'h00);
    wait_strobe(8'h10, ok);
    check("abort_strobe_seen", ok, 1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_en_drop", mem_en, 0);
    tgl = 1'b0;
    i2c_req_tgl = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    strobe_log.delete();
    repeat (4) step();
    check("abort_no_ack", i2c_ack_tgl, 0);
    check("abort_no_strobe", strobe_log.size(), 0);
    check("abort_hold", hold_clock_low, 0);
    check("abort_i2c_rdata", i2c_rdata, 0);

    // Host write 0x20 <= 0x3C: strobe next cycle, done the cycle after
    host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h3C; host_req = 1'b1;
    step();
    check("hw_strobe", mem_en, 1);
    check("hw_mem_we", mem_we, 1);
    check("hw_mem_addr", mem_addr, 8'h20);
    step();
    check("hw_done", host_done, 1);
    host_req = 1'b0;
    step();
    check("hw_done_pulse_end", host_done, 0);

    // Host read 0x20: done on the fourth cycle counting the pick cycle
    host_we = 1'b0; host_req = 1'b1;
    step();
    check("hr_strobe", mem_en, 1);
    check("hr_mem_we", mem_we, 0);
    step();
    check("hr_done_not_yet", host_done, 0);
    step();
    check("hr_done", host_done, 1);
    check("hr_rdata", host_rdata, 8'h3C);
    host_req = 1'b0;
    step();
    check("hr_done_pulse_end", host_done, 0);
    check("hr_rdata_held", host_rdata, 8'h3C);

    // Host and I2C become visible in the same cycle: I2C is served first
    strobe_log.delete();
    i2c_issue(1'b1, 8'h40, 8'h11);
    step();
    step();
    host_we = 1'b1; host_addr = 8'h50; host_wdata = 8'h22; host_req = 1'b1;
    drain(ok);
    check("sim_drain", ok, 1);
    check("sim_count", strobe_log.size(), 2);
    check("sim_first_i2c", strobe_log[0], 8'h40);
    check("sim_then_host", strobe_log[1], 8'h50);

    // Host held while I2C requests arrive back to back; each next request is presented
    // once the previous one is strobed, so it is already pending when the arbiter idles
    strobe_log.delete();
    for (int i = 0; i < 6; i++) begin
      i2c_issue(1'b1, 8'h30 + 8'(i), 8'(i));
      wait_strobe(8'h30 + 8'(i), ok);
      check("starve_strobe_seen", ok, 1);
      if (i == 0) begin
        host_we = 1'b1; host_addr = 8'h80; host_wdata = 8'h99; host_req = 1'b1;
      end
    end
    drain(ok);
    check("starve_drain", ok, 1);
    check("starve_count", strobe_log.size(), 7);
    for (int i = 0; i < 7; i++) check($sformatf("starve_order_%0d", i), strobe_log[i], exp_order[i]);

    // I2C write at 0xF4: blocked with write protect, reaches memory otherwise
    strobe_log.delete();
    wp_cnt = 0;
    ok = 1'b0;
    i2c_issue(1'b1, 8'hF4, 8'h5A);
    for (int k = 0; k < 40; k++) begin
      step();
`ifdef I2C_ARB_WP_EN
      if (wp_violation) wp_cnt++;
`endif
      if (i2c_ack_tgl == tgl) begin
        ok = 1'b1;
        break;
      end
    end
    check("f4_ack", ok, 1);
    step();
`ifdef I2C_ARB_WP_EN
    check("f4_no_strobe", strobe_log.size(), 0);
    check("f4_wp_pulse", wp_cnt, 1);
`else
    check("f4_strobe", strobe_log.size(), 1);
    check("f4_strobe_addr", strobe_log[0], 8'hF4);
`endif
    host_we = 1'b1; host_addr = 8'hF4; host_wdata = 8'h77; host_req = 1'b1;
    drain(ok);
    check("f4_host_wr_drain", ok, 1);
    check("f4_host_wr_addr", strobe_log[strobe_log.size() - 1], 8'hF4);
    host_we = 1'b0; host_req = 1'b1;
    drain(ok);
    check("f4_host_rd_drain", ok, 1);
    check("f4_host_rdata", host_rdata, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
